// File: rtl/fetch_stage.sv
// Fetch stage: PCF register, PC+4 generation, IF/ID pipeline register with
// hazard stall/flush, misaligned-fetch flagging and a saturating fetch counter.
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013,
  parameter int unsigned           CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic                  MisalignD,
  output logic [CNT_WIDTH-1:0]  FetchCnt
);

  logic [DATA_WIDTH-1:0] pcf_q;
  logic [DATA_WIDTH-1:0] instr_d_q;
  logic [DATA_WIDTH-1:0] pc_d_q;
  logic [DATA_WIDTH-1:0] pc_plus4_d_q;
  logic                  valid_d_q;
  logic                  misalign_d_q;
  logic [CNT_WIDTH-1:0]  fetch_cnt_q;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  pcf_misalign;
  logic                  load_d;
  logic                  cnt_sat;

  // Next-fetch address, misalignment and IF/ID load qualification
  always_comb begin
    pc_plus4     = pcf_q + DATA_WIDTH'(4);
    pcf_misalign = (pcf_q[1:0] != 2'b00);
    load_d       = !FlushD && !StallD;
    cnt_sat      = (fetch_cnt_q == {CNT_WIDTH{1'b1}});
  end

  // Program counter: follows the selected next-PC unless the fetch is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q <= RESET_VECTOR;
    end else if (!StallF) begin
      pcf_q <= pc;
    end
  end

  // IF/ID register: flush beats stall beats load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
      misalign_d_q <= 1'b0;
    end else if (FlushD) begin
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
      misalign_d_q <= 1'b0;
    end else if (!StallD) begin
      // A misaligned fetch still advances decode, but carries a bubble word
      instr_d_q    <= pcf_misalign ? NOP_INSTR : InstrF;
      pc_d_q       <= pcf_q;
      pc_plus4_d_q <= pc_plus4;
      valid_d_q    <= 1'b1;
      misalign_d_q <= pcf_misalign;
    end
  end

  // Fetch counter: counts IF/ID loads, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
    end else if (load_d && !cnt_sat) begin
      fetch_cnt_q <= fetch_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign PCF       = pcf_q;
  assign PCPlus4F  = pc_plus4;
  assign InstrD    = instr_d_q;
  assign PCD       = pc_d_q;
  assign PCPlus4D  = pc_plus4_d_q;
  assign ValidD    = valid_d_q;
  assign MisalignD = misalign_d_q;
  assign FetchCnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes expected post-edge state,
// monitor pops and compares after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] RV  = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        StallF, StallD, FlushD;
  logic [31:0] InstrF, InstrF4;
  logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic        ValidD, MisalignD;
  logic [31:0] FetchCnt;
  logic [31:0] PCF4, PCPlus4F4, InstrD4, PCD4, PCPlus4D4;
  logic        ValidD4, MisalignD4;
  logic [3:0]  FetchCnt4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] pcp4f;
    logic [31:0] instrd;
    logic [31:0] pcd;
    logic [31:0] pcp4d;
    logic        valid;
    logic        mis;
    longint      cnt32;
    longint      cnt4;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state (state after the most recent edge)
  logic [31:0] m_pcf;
  logic [31:0] m_instrd, m_pcd, m_pcp4d;
  logic        m_valid, m_mis;
  longint      m_cnt32, m_cnt4;

  // Instruction memory contents: arbitrary but address-dependent
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == RV) return 32'h0050_0093;
    return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1234};
  endfunction

  assign InstrF  = imem(PCF);
  assign InstrF4 = imem(PCF4);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignD(MisalignD), .FetchCnt(FetchCnt)
  );

  fetch_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .pc(pc), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF4), .PCF(PCF4), .PCPlus4F(PCPlus4F4), .InstrD(InstrD4), .PCD(PCD4),
    .PCPlus4D(PCPlus4D4), .ValidD(ValidD4), .MisalignD(MisalignD4), .FetchCnt(FetchCnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcf    = RV;
    m_instrd = NOP;
    m_pcd    = '0;
    m_pcp4d  = '0;
    m_valid  = 1'b0;
    m_mis    = 1'b0;
    m_cnt32  = 0;
    m_cnt4   = 0;
  endtask

  // Called at a negedge: drive inputs, advance model, push expectation, wait for next negedge
  task automatic step(input logic [31:0] pcv, input logic sf, input logic sd, input logic fd);
    exp_t e;
    pc = pcv; StallF = sf; StallD = sd; FlushD = fd;
    if (fd) begin
      m_instrd = NOP; m_pcd = '0; m_pcp4d = '0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (!sd) begin
      m_mis    = (m_pcf % 4) != 0;
      m_instrd = m_mis ? NOP : imem(m_pcf);
      m_pcd    = m_pcf;
      m_pcp4d  = 32'((64'(m_pcf) + 64'd4) % 64'h1_0000_0000);
      m_valid  = 1'b1;
      m_cnt32  = (m_cnt32 < 64'hFFFF_FFFF) ? m_cnt32 + 1 : m_cnt32;
      m_cnt4   = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
    end
    if (!sf) m_pcf = pcv;
    e.pcf    = m_pcf;
    e.pcp4f  = 32'((64'(m_pcf) + 64'd4) % 64'h1_0000_0000);
    e.instrd = m_instrd;
    e.pcd    = m_pcd;
    e.pcp4d  = m_pcp4d;
    e.valid  = m_valid;
    e.mis    = m_mis;
    e.cnt32  = m_cnt32;
    e.cnt4   = m_cnt4;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(m_pcf + 32'd4, 1'b0, 1'b0, 1'b0);
  endtask

  // Async reset mid-cycle: outputs must change before any clock edge
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_PCF", 64'(PCF), 64'(RV));
    chk("rst_ValidD", 64'(ValidD), 64'd0);
    chk("rst_InstrD", 64'(InstrD), 64'(NOP));
    chk("rst_PCD", 64'(PCD), 64'd0);
    chk("rst_MisalignD", 64'(MisalignD), 64'd0);
    chk("rst_FetchCnt", 64'(FetchCnt), 64'd0);
    chk("rst_FetchCnt4", 64'(FetchCnt4), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every edge that has a pending expectation is compared
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("PCF", 64'(PCF), 64'(e.pcf));
      chk("PCPlus4F", 64'(PCPlus4F), 64'(e.pcp4f));
      chk("InstrD", 64'(InstrD), 64'(e.instrd));
      chk("PCD", 64'(PCD), 64'(e.pcd));
      chk("PCPlus4D", 64'(PCPlus4D), 64'(e.pcp4d));
      chk("ValidD", 64'(ValidD), 64'(e.valid));
      chk("MisalignD", 64'(MisalignD), 64'(e.mis));
      chk("FetchCnt", 64'(FetchCnt), 64'(e.cnt32));
      chk("FetchCnt4", 64'(FetchCnt4), 64'(e.cnt4));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [31:0] nxt;
    rst = 1'b1; pc = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    model_reset();
    #1;
    chk("init_PCF", 64'(PCF), 64'(RV));
    chk("init_InstrD", 64'(InstrD), 64'(NOP));
    chk("init_ValidD", 64'(ValidD), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch to 0xBFC0_0010, then reset mid-run
    seq(4);
    async_reset();
    // First load after release, then sequential fetch
    seq(5);
    // Sit at 0xBFC0_0008-style stall: hold both F and D two cycles
    step(m_pcf, 1'b1, 1'b1, 1'b0);
    step(m_pcf, 1'b1, 1'b1, 1'b0);
    seq(1);
    // Flush beats stall; redirect via pc
    step(RV + 32'h40, 1'b0, 1'b1, 1'b1);
    seq(1);
    // Misaligned redirect
    step(RV + 32'h42, 1'b0, 1'b0, 1'b0);
    seq(2);
    // StallF alone: same PCF loaded repeatedly
    step(m_pcf, 1'b1, 1'b0, 1'b0);
    step(m_pcf, 1'b1, 1'b0, 1'b0);
    // PC wrap
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    seq(3);

    // Random traffic with occasional async resets
    for (int i = 0; i < 400; i++) begin
      if (i % 137 == 136) async_reset();
      r = $urandom_range(0, 99);
      if (r < 70)      nxt = m_pcf + 32'd4;
      else if (r < 85) nxt = $urandom() & 32'hFFFF_FFFC;
      else if (r < 92) nxt = $urandom();
      else             nxt = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
      step(nxt, ($urandom() % 8) == 0, ($urandom() % 6) == 0, ($urandom() % 10) == 0);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Fetch-stage state for the 5-stage RISC-V pipeline, directly downstream of counter_module. It holds the program counter register PCF, which loads counter_module's selected next-PC, and generates PCPlus4F, which feeds back into counter_module. It also implements the IF/ID pipeline register with hazard-unit stall and flush control, and flags misaligned fetches. A saturating fetch counter supports performance debug.

Parameters:
DATA_WIDTH, 32, width of PC and instruction words
RESET_VECTOR, 32'hBFC0_0000, PCF value on reset (instruction ROM base)
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)
CNT_WIDTH, 32, width of fetch counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
pc  input  DATA_WIDTH  next PC selected by counter_module
StallF  input  1  hazard unit: hold PCF
StallD  input  1  hazard unit: hold IF/ID register
FlushD  input  1  hazard unit: squash IF/ID (taken branch/jump)
InstrF  input  DATA_WIDTH  instruction word from instruction memory, combinational read of PCF
PCF  output  DATA_WIDTH  current fetch address to instruction memory
PCPlus4F  output  DATA_WIDTH  PCF+4, to counter_module
InstrD  output  DATA_WIDTH  decode-stage instruction
PCD  output  DATA_WIDTH  decode-stage PC
PCPlus4D  output  DATA_WIDTH  decode-stage PC+4
ValidD  output  1  InstrD is a real fetched instruction, not a bubble
MisalignD  output  1  decode-stage instruction was fetched from a PC with PC[1:0]!=0
FetchCnt  output  CNT_WIDTH  count of valid instructions entering decode

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - PCF=RESET_VECTOR
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0
  - ValidD=0, MisalignD=0, FetchCnt=0
- PCPlus4F = PCF + 4, combinational, truncated to DATA_WIDTH (0xFFFF_FFFC -> 0x0000_0000).
- PCF register, each rising edge:
  - StallF=0: PCF <= pc.
  - StallF=1: PCF holds.
  - FlushD has no effect on PCF; redirects arrive through pc.
- IF/ID register, each rising edge. Priority is FlushD > StallD > load.
  - FlushD=1: InstrD<=NOP_INSTR, ValidD<=0, MisalignD<=0; PCD and PCPlus4D are loaded with 0.
  - FlushD=0, StallD=1: all D outputs hold.
  - Otherwise (load): PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1, MisalignD<=(PCF[1:0]!=0).
    - If PCF is misaligned: InstrD<=NOP_INSTR.
    - Else: InstrD<=InstrF.
- FetchCnt:
  - Increments by 1 on every edge where the IF/ID register performs a load.
  - Saturates at all-ones; does not wrap.
  - Flush and stall cycles do not count.
- Latency: an address presented on pc reaches PCF one edge later. The instruction at PCF appears on InstrD on the next unstalled edge.
- First edge after reset deassertion, with no stall or flush: InstrD gets the RESET_VECTOR instruction, ValidD=1.
- StallF=1 with StallD=0 is legal: the same PCF is loaded into decode repeatedly.
- The block has no internal state machine beyond the registers above. No combinational path exists from pc to any output other than through PCF.

Test Plan:
- Reset release: assert rst mid-run with PCF=0xBFC0_0010 -> immediately PCF=0xBFC0_0000, ValidD=0, InstrD=0x13, FetchCnt=0. After release with pc=PCPlus4F and InstrF=0x00500093 -> next edge InstrD=0x00500093, PCD=0xBFC0_0000, PCPlus4D=0xBFC0_0004, ValidD=1, FetchCnt=1.
- Sequential fetch: 4 edges with pc=PCPlus4F -> PCF steps 0xBFC0_0004, …0010; FetchCnt=4.
- Stall: StallF=StallD=1 for 2 cycles at PCF=0xBFC0_0008 -> PCF, InstrD, PCD, FetchCnt unchanged. On release, PCD=0xBFC0_0008.
- Flush priority: FlushD=StallD=1, pc=0xBFC0_0040 -> InstrD=0x13, ValidD=0, PCD=0, FetchCnt unchanged; PCF=0xBFC0_0040 next edge.
- Misaligned: pc=0xBFC0_0042 -> following load gives MisalignD=1, InstrD=0x13, ValidD=1, PCD=0xBFC0_0042.
- Wrap/saturation: PCF=0xFFFF_FFFC -> PCPlus4F=0x0000_0000. Force FetchCnt to all-ones with CNT_WIDTH=4 -> stays 4'hF after further loads.
